// File: rtl/pe_pkg.sv
// Shared types, widths and result helper for the PE MAC sequencer.
// PE_MAC_SAT_EN selects saturating (defined) or truncating (default) psum results.
package pe_pkg;

  localparam int unsigned DATA_BITWIDTH = 16;
  localparam int unsigned ADDR_BITWIDTH = 9;
  localparam int unsigned ACC_BITWIDTH  = 32;
  localparam int unsigned LEN_BITWIDTH  = 9;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_e;

  // Reduces a sign-extended accumulator to a dw-bit result; caller keeps the low dw bits.
  function automatic logic [63:0] sat_trunc(input logic signed [63:0] acc, input int unsigned dw);
`ifdef PE_MAC_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (acc > hi) return hi;
    else if (acc < lo) return lo;
    else return acc;
`else
    return acc & ((64'd1 << dw) - 64'd1);
`endif
  endfunction

endpackage

// File: rtl/pe_mac_sequencer_if.sv
// SPad-side bus of the MAC sequencer: ifmap/filter read ports and psum write port.
interface pe_mac_sequencer_if #(
  parameter int unsigned DATA_BITWIDTH = pe_pkg::DATA_BITWIDTH,
  parameter int unsigned ADDR_BITWIDTH = pe_pkg::ADDR_BITWIDTH
) ();

  logic                     ifmap_rd_req;
  logic [ADDR_BITWIDTH-1:0] ifmap_r_addr;
  logic [DATA_BITWIDTH-1:0] ifmap_r_data;
  logic                     filt_rd_req;
  logic [ADDR_BITWIDTH-1:0] filt_r_addr;
  logic [DATA_BITWIDTH-1:0] filt_r_data;
  logic                     psum_we;
  logic [ADDR_BITWIDTH-1:0] psum_w_addr;
  logic [DATA_BITWIDTH-1:0] psum_w_data;

  modport master (
    output ifmap_rd_req, ifmap_r_addr, filt_rd_req, filt_r_addr,
    output psum_we, psum_w_addr, psum_w_data,
    input  ifmap_r_data, filt_r_data
  );

  modport slave (
    input  ifmap_rd_req, ifmap_r_addr, filt_rd_req, filt_r_addr,
    input  psum_we, psum_w_addr, psum_w_data,
    output ifmap_r_data, filt_r_data
  );

endinterface

// File: rtl/pe_mac_unit.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module pe_mac_unit #(
  parameter int unsigned DATA_BITWIDTH = pe_pkg::DATA_BITWIDTH,
  parameter int unsigned ACC_BITWIDTH  = pe_pkg::ACC_BITWIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            en,
  input  logic signed [DATA_BITWIDTH-1:0] a,
  input  logic signed [DATA_BITWIDTH-1:0] b,
  output logic signed [ACC_BITWIDTH-1:0]  acc
);

  logic signed [2*DATA_BITWIDTH-1:0] prod;
  logic signed [ACC_BITWIDTH-1:0]    acc_d;
  logic signed [ACC_BITWIDTH-1:0]    acc_q;

  assign prod = a * b;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + ACC_BITWIDTH'(prod);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pe_mac_sequencer.sv
// Issues N paired ifmap/filter SPad reads, accumulates the signed products and writes one psum.
// Build option PE_MAC_SAT_EN: saturate the psum instead of truncating it.
module pe_mac_sequencer #(
  parameter int unsigned DATA_BITWIDTH = pe_pkg::DATA_BITWIDTH,
  parameter int unsigned ADDR_BITWIDTH = pe_pkg::ADDR_BITWIDTH,
  parameter int unsigned ACC_BITWIDTH  = pe_pkg::ACC_BITWIDTH,
  parameter int unsigned LEN_BITWIDTH  = pe_pkg::LEN_BITWIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_BITWIDTH-1:0]  filt_len,
  input  logic [ADDR_BITWIDTH-1:0] ifmap_base,
  input  logic [ADDR_BITWIDTH-1:0] filt_base,
  input  logic [ADDR_BITWIDTH-1:0] psum_addr,
  output logic                     busy,
  output logic                     done,
  pe_mac_sequencer_if.master       spad
);

  import pe_pkg::*;

  state_e                   state_q, state_d;
  logic [LEN_BITWIDTH-1:0]  len_q, len_d;
  logic [LEN_BITWIDTH-1:0]  idx_q, idx_d;
  logic [ADDR_BITWIDTH-1:0] ifmap_base_q, ifmap_base_d;
  logic [ADDR_BITWIDTH-1:0] filt_base_q, filt_base_d;
  logic [ADDR_BITWIDTH-1:0] psum_addr_q, psum_addr_d;
  logic                     rd_valid_q;
  logic                     mac_clear;
  logic signed [ACC_BITWIDTH-1:0] mac_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      ifmap_base_q <= '0;
      filt_base_q  <= '0;
      psum_addr_q  <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      ifmap_base_q <= ifmap_base_d;
      filt_base_q  <= filt_base_d;
      psum_addr_q  <= psum_addr_d;
      rd_valid_q   <= (state_q == READ);
    end
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    idx_d        = idx_q;
    ifmap_base_d = ifmap_base_q;
    filt_base_d  = filt_base_q;
    psum_addr_d  = psum_addr_q;
    mac_clear    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d        = filt_len;
          ifmap_base_d = ifmap_base;
          filt_base_d  = filt_base;
          psum_addr_d  = psum_addr;
          idx_d        = '0;
          mac_clear    = 1'b1;
          // A zero-tap job still passes through DRAIN so latency stays N+2 for every N.
          state_d      = (filt_len == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        idx_d = idx_q + LEN_BITWIDTH'(1);
        if (idx_q == len_q - LEN_BITWIDTH'(1)) state_d = DRAIN;
      end
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state_q != IDLE);
    done              = (state_q == WRITE);
    spad.ifmap_rd_req = (state_q == READ);
    spad.filt_rd_req  = (state_q == READ);
    spad.ifmap_r_addr = '0;
    spad.filt_r_addr  = '0;
    spad.psum_we      = (state_q == WRITE);
    spad.psum_w_addr  = '0;
    spad.psum_w_data  = '0;
    if (state_q == READ) begin
      spad.ifmap_r_addr = ifmap_base_q + ADDR_BITWIDTH'(idx_q);
      spad.filt_r_addr  = filt_base_q + ADDR_BITWIDTH'(idx_q);
    end
    if (state_q == WRITE) begin
      spad.psum_w_addr = psum_addr_q;
      spad.psum_w_data = DATA_BITWIDTH'(sat_trunc(64'(mac_acc), DATA_BITWIDTH));
    end
  end

  // r_data is only meaningful the cycle after a read request.
  pe_mac_unit #(
    .DATA_BITWIDTH(DATA_BITWIDTH),
    .ACC_BITWIDTH (ACC_BITWIDTH)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .clear(mac_clear),
    .en   (rd_valid_q),
    .a    (spad.ifmap_r_data),
    .b    (spad.filt_r_data),
    .acc  (mac_acc)
  );

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed self-checking bench for pe_mac_sequencer with behavioural SPad models.
module tb_pe_mac_sequencer;

  localparam int D = 16;
  localparam int A = 9;
  localparam int L = 9;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [L-1:0] filt_len = '0;
  logic [A-1:0] ifmap_base = '0;
  logic [A-1:0] filt_base = '0;
  logic [A-1:0] psum_addr = '0;
  logic         busy;
  logic         done;

  pe_mac_sequencer_if #(.DATA_BITWIDTH(D), .ADDR_BITWIDTH(A)) spad ();

  pe_mac_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .filt_len  (filt_len),
    .ifmap_base(ifmap_base),
    .filt_base (filt_base),
    .psum_addr (psum_addr),
    .busy      (busy),
    .done      (done),
    .spad      (spad)
  );

  always #5 clk = ~clk;

  logic [D-1:0] ifmap_mem [512];
  logic [D-1:0] filt_mem  [512];
  logic [D-1:0] psum_mem  [512];

  // SPads: one-cycle registered read, filler value when not requested.
  always @(posedge clk) begin
    spad.ifmap_r_data <= spad.ifmap_rd_req ? ifmap_mem[spad.ifmap_r_addr] : 16'hDEAD;
    spad.filt_r_data  <= spad.filt_rd_req ? filt_mem[spad.filt_r_addr] : 16'hBEEF;
    if (spad.psum_we) psum_mem[spad.psum_w_addr] <= spad.psum_w_data;
  end

  int passed = 0;
  int total = 0;

  int           done_cyc, rd_cycles, we_count, pair_err;
  logic         busy_after;
  logic [D-1:0] we_data;
  logic [A-1:0] ifmap_log[$];
  logic [A-1:0] filt_log[$];

  // Called at a negedge; start is sampled at the next posedge (cycle 0).
  task automatic run_op(input int n, input int ib, input int fb, input int pa, input int budget);
    ifmap_log.delete();
    filt_log.delete();
    done_cyc = -1; rd_cycles = 0; we_count = 0; pair_err = 0; we_data = '0;
    filt_len = L'(n); ifmap_base = A'(ib); filt_base = A'(fb); psum_addr = A'(pa);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      if (spad.filt_rd_req !== spad.ifmap_rd_req || done !== spad.psum_we) pair_err++;
      if (spad.ifmap_rd_req === 1'b1) begin
        rd_cycles++;
        ifmap_log.push_back(spad.ifmap_r_addr);
        filt_log.push_back(spad.filt_r_addr);
      end
      if (spad.psum_we === 1'b1) begin
        we_count++;
        we_data = spad.psum_w_data;
        if (done_cyc < 0) done_cyc = c;
      end
      @(negedge clk);
      if (done_cyc >= 0) break;
    end
    busy_after = busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done, spad.ifmap_rd_req, spad.filt_rd_req, spad.psum_we} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {busy, done, spad.ifmap_rd_req, spad.filt_rd_req, spad.psum_we});
    else passed++;
    total++;
    if ({spad.ifmap_r_addr, spad.filt_r_addr, spad.psum_w_addr, spad.psum_w_data} !== '0)
      $display("FAIL reset_bus: got %h want 0",
               {spad.ifmap_r_addr, spad.filt_r_addr, spad.psum_w_addr, spad.psum_w_data});
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    ifmap_mem[0] = 16'd1; ifmap_mem[1] = 16'd2; ifmap_mem[2] = 16'd3;
    filt_mem[0]  = 16'd4; filt_mem[1]  = 16'd5; filt_mem[2]  = 16'd6;
    run_op(3, 0, 0, 500, 20);
    total++;
    if (done_cyc !== 5) $display("FAIL basic_done_cycle: got %0d want 5", done_cyc);
    else passed++;
    total++;
    if (psum_mem[500] !== 16'd32) $display("FAIL basic_psum: got %0d want 32", psum_mem[500]);
    else passed++;
    total++;
    if (rd_cycles !== 3 || pair_err !== 0 || we_count !== 1)
      $display("FAIL basic_handshake: rd=%0d err=%0d we=%0d want 3/0/1",
               rd_cycles, pair_err, we_count);
    else passed++;
    total++;
    if (busy_after !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy_after);
    else passed++;
  endtask

  task automatic test_signed();
    ifmap_mem[10] = 16'hFFFD; ifmap_mem[11] = 16'd7;
    filt_mem[20]  = 16'd2;    filt_mem[21]  = 16'hFFFF;
    run_op(2, 10, 20, 40, 20);
    total++;
    if (psum_mem[40] !== 16'hFFF3) $display("FAIL signed_psum: got %h want fff3", psum_mem[40]);
    else passed++;
    total++;
    if (rd_cycles !== 2 || done_cyc !== 4)
      $display("FAIL signed_timing: rd=%0d done=%0d want 2/4", rd_cycles, done_cyc);
    else passed++;
  endtask

  task automatic test_zero_len();
    psum_mem[7] = 16'h1234;
    run_op(0, 0, 0, 7, 20);
    total++;
    if (done_cyc !== 2) $display("FAIL zero_done_cycle: got %0d want 2", done_cyc);
    else passed++;
    total++;
    if (rd_cycles !== 0) $display("FAIL zero_no_reads: got %0d want 0", rd_cycles);
    else passed++;
    total++;
    if (psum_mem[7] !== 16'h0000) $display("FAIL zero_psum: got %h want 0000", psum_mem[7]);
    else passed++;
  endtask

  task automatic test_wrap();
    int exp_i[4] = '{510, 511, 0, 1};
    ifmap_mem[510] = 16'd1; ifmap_mem[511] = 16'd2; ifmap_mem[0] = 16'd3; ifmap_mem[1] = 16'd4;
    for (int i = 0; i < 4; i++) filt_mem[300 + i] = 16'd2;
    run_op(4, 510, 300, 50, 20);
    total++;
    if (ifmap_log.size() !== 4) begin
      $display("FAIL wrap_len: got %0d want 4", ifmap_log.size());
    end else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (ifmap_log[i] !== A'(exp_i[i]) || filt_log[i] !== A'(300 + i))
          $display("FAIL wrap_addr%0d: got %0d/%0d want %0d/%0d",
                   i, ifmap_log[i], filt_log[i], exp_i[i], 300 + i);
        else passed++;
      end
    end
    total++;
    if (psum_mem[50] !== 16'd20) $display("FAIL wrap_psum: got %0d want 20", psum_mem[50]);
    else passed++;
  endtask

  task automatic test_saturation();
    logic [D-1:0] exp_p;
`ifdef PE_MAC_SAT_EN
    exp_p = 16'h7FFF;
`else
    exp_p = 16'h3880;
`endif
    ifmap_mem[40] = 16'd200; ifmap_mem[41] = 16'd200;
    filt_mem[60]  = 16'd200; filt_mem[61]  = 16'd200;
    run_op(2, 40, 60, 8, 20);
    total++;
    if (psum_mem[8] !== exp_p) $display("FAIL sat_psum: got %h want %h", psum_mem[8], exp_p);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int we_seen = 0;
    psum_mem[60] = 16'hAAAA;
    filt_len = L'(5); ifmap_base = '0; filt_base = '0; psum_addr = A'(60);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || spad.psum_we !== 1'b0 || done !== 1'b0)
      $display("FAIL midreset_idle: busy=%b we=%b done=%b want 0/0/0",
               busy, spad.psum_we, done);
    else passed++;
    reset = 1'b0;
    repeat (10) begin
      if (spad.psum_we === 1'b1 || done === 1'b1) we_seen++;
      @(negedge clk);
    end
    total++;
    if (we_seen !== 0 || psum_mem[60] !== 16'hAAAA)
      $display("FAIL midreset_nowrite: we=%0d psum=%h want 0/aaaa", we_seen, psum_mem[60]);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int dones = 0;
    int first = -1;
    for (int i = 0; i < 3; i++) begin
      ifmap_mem[100 + i] = 16'd1;
      filt_mem[100 + i]  = 16'd3;
    end
    psum_mem[20] = '0; psum_mem[21] = 16'h5555;
    filt_len = L'(3); ifmap_base = A'(100); filt_base = A'(100); psum_addr = A'(20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 2) begin
        start = 1'b1; psum_addr = A'(21); filt_len = L'(1); ifmap_base = A'(0);
      end
      if (c == 3) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first < 0) first = c;
      end
      @(negedge clk);
    end
    total++;
    if (dones !== 1 || first !== 5)
      $display("FAIL busy_start_done: count=%0d cycle=%0d want 1/5", dones, first);
    else passed++;
    total++;
    if (psum_mem[20] !== 16'd9 || psum_mem[21] !== 16'h5555)
      $display("FAIL busy_start_psum: p20=%h p21=%h want 0009/5555", psum_mem[20], psum_mem[21]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    ifmap_mem[200] = 16'hFFFE; filt_mem[200] = 16'd9;
    ifmap_mem[201] = 16'd5;    filt_mem[201] = 16'd5;
    ifmap_mem[202] = 16'd6;    filt_mem[202] = 16'd6;
    run_op(1, 200, 200, 30, 20);
    total++;
    if (done_cyc !== 3) $display("FAIL b2b_first_cycle: got %0d want 3", done_cyc);
    else passed++;
    // Starts in cycle N+3 of the first job.
    run_op(2, 201, 201, 31, 20);
    total++;
    if (done_cyc !== 4) $display("FAIL b2b_second_cycle: got %0d want 4", done_cyc);
    else passed++;
    total++;
    if (psum_mem[30] !== 16'hFFEE || psum_mem[31] !== 16'h003D)
      $display("FAIL b2b_psum: got %h/%h want ffee/003d", psum_mem[30], psum_mem[31]);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      ifmap_mem[i] = '0;
      filt_mem[i]  = '0;
      psum_mem[i]  = '0;
    end
    @(negedge clk);
    test_reset();
    test_basic();
    test_signed();
    test_zero_len();
    test_wrap();
    test_saturation();
    test_reset_mid();
    test_start_while_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
